// File: rtl/grant_decoder_pkg.sv
// Shared types and widths for the grant decoder and its timeout counter.
package grant_decoder_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned LINE_W  = 4;
  // Wide enough for the largest supported timeout (255 cycles).
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Binary line index to one-hot grant vector.
  function automatic logic [LINE_W-1:0] decode_line(input logic [CODE_W-1:0] line_code);
    decode_line = LINE_W'(1) << line_code;
  endfunction

endpackage

// File: rtl/grant_timer.sv
// Counts consecutive GRANT cycles without ack; expired flags the last allowed cycle.
module grant_timer
  import grant_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Terminal count reached: this is the final GRANT cycle unless ack arrives.
  assign expired = (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Next count: clear on grant entry, otherwise advance and hold at terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/grant_decoder.sv
// Grant decoder: latches a binary line code into a registered one-hot grant,
// holds it until ack, then inserts one RELEASE guard cycle before the next grant.
// Optional forced release after TIMEOUT_CYCLES is enabled by GRANT_DECODER_TIMEOUT_EN.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  input  logic       valid,
  output logic       ready,
  input  logic       ack,
  output logic [3:0] onehot,
  output logic       active,
  output logic       timeout
);

  state_e            state_q;
  state_e            state_d;
  logic [LINE_W-1:0] onehot_q;
  logic [LINE_W-1:0] onehot_d;
  logic              active_q;
  logic              active_d;
  logic              timeout_q;
  logic              timeout_d;
  logic              accept;
  logic              timer_expired;

  // Ready is a pure decode of the state register; only IDLE takes a new code.
  assign ready  = (state_q == IDLE);
  assign accept = ready && valid;

`ifdef GRANT_DECODER_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  // Timer restarts on each accept and runs only while a grant is waiting for ack.
  assign timer_clear  = accept;
  assign timer_enable = (state_q == GRANT) && !ack;

  grant_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_grant_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );
`else
  // Without the timeout feature a grant is held until ack; no counter exists.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMER_W'(TIMEOUT_CYCLES);
  assign timer_expired      = 1'b0;
`endif

  // Next-state and next-output decode; ack beats a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    active_d  = active_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        onehot_d = '0;
        active_d = 1'b0;
        if (accept) begin
          state_d  = GRANT;
          onehot_d = decode_line(code);
          active_d = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d  = RELEASE;
          onehot_d = '0;
          active_d = 1'b0;
        end else if (timer_expired) begin
          state_d   = RELEASE;
          onehot_d  = '0;
          active_d  = 1'b0;
          timeout_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        onehot_d = '0;
        active_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      onehot_q  <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  assign onehot  = onehot_q;
  assign active  = active_q;
  assign timeout = timeout_q;

  // Structural invariants of the grant outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(onehot_q))
        else $error("grant_decoder: more than one line granted");
      assert (active_q == (onehot_q != '0))
        else $error("grant_decoder: active disagrees with onehot");
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Scoreboard bench for grant_decoder; each step pushes the expected outputs
// when inputs are driven and pops/compares one cycle later.
module tb_grant_decoder;

  localparam int unsigned TO_CYC = 4;

  typedef struct packed {
    logic [3:0] onehot;
    logic       active;
    logic       ready;
    logic       timeout;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] code;
    logic       ack;
    obs_t       exp;
  } step_t;

  logic       clk;
  logic       rst;
  logic [1:0] code;
  logic       valid;
  logic       ready;
  logic       ack;
  logic [3:0] onehot;
  logic       active;
  logic       timeout_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  grant_decoder #(
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .ack     (ack),
    .onehot  (onehot),
    .active  (active),
    .timeout (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output constructors.
  function automatic obs_t o_idle();
    obs_t o;
    o = {4'b0000, 1'b0, 1'b1, 1'b0};
    return o;
  endfunction

  function automatic obs_t o_rel(input logic to);
    obs_t o;
    o = {4'b0000, 1'b0, 1'b0, to};
    return o;
  endfunction

  function automatic obs_t o_grant(input logic [1:0] c);
    obs_t o;
    case (c)
      2'd0:    o.onehot = 4'b0001;
      2'd1:    o.onehot = 4'b0010;
      2'd2:    o.onehot = 4'b0100;
      default: o.onehot = 4'b1000;
    endcase
    o.active  = 1'b1;
    o.ready   = 1'b0;
    o.timeout = 1'b0;
    return o;
  endfunction

  function automatic step_t mk(input logic r, input logic v, input logic [1:0] c,
                               input logic a, input obs_t e);
    step_t s;
    s.rst   = r;
    s.valid = v;
    s.code  = c;
    s.ack   = a;
    s.exp   = e;
    return s;
  endfunction

  task automatic test_reset();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, o_idle()));
    tbl.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, o_idle()));
    tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, o_grant(2'd2)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_grant(2'd2)));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, o_idle()));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, o_idle()));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, o_grant(2'd3)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_decode_sweep();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    for (int c = 0; c < 4; c++) begin
      tbl.push_back(mk(1'b0, 1'b1, 2'(c), 1'b0, o_grant(2'(c))));
      tbl.push_back(mk(1'b0, 1'b0, 2'(c), 1'b1, o_rel(1'b0)));
      tbl.push_back(mk(1'b0, 1'b1, 2'(c), 1'b0, o_idle()));
    end
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL decode_sweep step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_ignore_busy();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, o_grant(2'd1)));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, o_grant(2'd1)));
    tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, o_idle()));
    tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, o_grant(2'd3)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ignore_busy step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_stray_ack();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_idle()));
    tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, o_grant(2'd2)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_grant(2'd2)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_idle()));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_idle()));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stray_ack step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask

`ifdef GRANT_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    // No ack: grant visible for TO_CYC cycles, then forced release with a pulse.
    tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, o_grant(2'd0)));
    for (int k = 1; k < int'(TO_CYC); k++) tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_grant(2'd0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_rel(1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    // Ack on the expiry cycle wins: release without a pulse.
    tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, o_grant(2'd0)));
    for (int k = 1; k < int'(TO_CYC); k++) tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, o_grant(2'd0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask
`else
  task automatic test_hold_no_timeout();
    step_t tbl[$];
    obs_t  got;
    obs_t  want;
    tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, o_grant(2'd3)));
    for (int k = 0; k < 1000; k++)
      tbl.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, o_grant(2'd3)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, o_rel(1'b0)));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, o_idle()));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].valid; code = tbl[i].code; ack = tbl[i].ack;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      got  = {onehot, active, ready, timeout_o};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hold_no_timeout step %0d: got {onehot,active,ready,timeout}=%b want %b", i, got, want);
      end
    end
  endtask
`endif

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    ack   = 1'b0;
    code  = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_decode_sweep();
    test_ignore_busy();
    test_stray_ack();
`ifdef GRANT_DECODER_TIMEOUT_EN
    test_timeout();
`else
    test_hold_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 15, number of GRANT cycles without ack before forced release (range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: code  input  2  binary index of the granted line; 2'b00 selects line 0, 2'b11 selects line 3.
REQ-005 SHALL have port: valid  input  1  code is meaningful this cycle.
REQ-006 SHALL have port: ready  output  1  block can accept a code.
REQ-007 SHALL have port: ack  input  1  requester on the active line releases the grant.
REQ-008 SHALL have port: onehot  output  4  registered one-hot grant; bit k high means line k is granted.
REQ-009 SHALL have port: active  output  1  registered; high exactly when onehot is nonzero.
REQ-010 SHALL have port: timeout  output  1  registered single-cycle pulse on forced release; constant 0 when the feature is compiled out.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-012 SHALL drive ready = 1 only in IDLE, decoded from the state register.
REQ-013 SHALL accept a code only when valid && ready at a rising edge; valid outside IDLE is ignored with no effect.
REQ-014 IDLE -> GRANT on accept; at that same edge onehot SHALL load 1 << code and active SHALL load 1 (latency: one edge).
REQ-015 In GRANT, onehot SHALL hold the captured value; changes on code/valid SHALL be ignored.
REQ-016 GRANT -> RELEASE when ack is sampled high; onehot SHALL go 4'b0000 and active 0 at that edge.
REQ-017 RELEASE -> IDLE unconditionally after one cycle; ready SHALL be 0 during RELEASE (one guard cycle between grants).
REQ-018 ack sampled in IDLE or RELEASE, or in the same cycle as accept, SHALL be ignored.
REQ-019 onehot SHALL never have more than one bit set; onehot SHALL be 0 in IDLE and RELEASE.
REQ-020 Minimum grant-to-grant spacing SHALL be 3 cycles (accept, ack, release).

Reset
REQ-021 rst high at an edge SHALL force state IDLE, onehot 4'b0000, active 0, timeout 0, timer count 0.
REQ-022 While rst is high, valid and ack SHALL be ignored; ready SHALL read 1 in the first cycle after rst is sampled high.
REQ-023 Reset during GRANT SHALL drop onehot at that edge without a timeout pulse.

Configuration
REQ-024 Macro GRANT_DECODER_TIMEOUT_EN defined: a counter SHALL clear on entry to GRANT, increment each GRANT cycle without ack, and when it equals TIMEOUT_CYCLES-1 with ack low, force GRANT -> RELEASE, clear onehot/active and pulse timeout for exactly one cycle.
REQ-025 With the macro defined, ack and timeout condition in the same cycle: ack wins, timeout stays 0.
REQ-026 Macro undefined: no counter logic; GRANT is held indefinitely until ack; timeout tied to 0.

Structure
REQ-027 Package grant_decoder_pkg SHALL hold the state typedef (IDLE, GRANT, RELEASE), CODE_W = 2 and LINE_W = 4.
REQ-028 Timeout counter SHALL be sub-module grant_timer (inputs clk, rst, clear, enable; output expired), instantiated only under GRANT_DECODER_TIMEOUT_EN.

Verification
REQ-029 Reset: rst high 2 cycles mid-GRANT with onehot=4'b0100 -> onehot 0, active 0, timeout 0 next edge; ready 1 after release of rst.
REQ-030 Decode sweep: code 0..3 each with valid, ack 2 cycles later -> onehot 0001, 0010, 0100, 1000 respectively, active high in step, 3-cycle spacing.
REQ-031 Ignore-while-busy: accept code 1, then valid with code 3 during GRANT -> onehot stays 4'b0010, ready 0 until RELEASE completes.
REQ-032 Stray ack: ack high in IDLE and in accept cycle with code 2 -> onehot 4'b0100 held; ack one cycle later releases.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=4): accept code 0, no ack -> onehot 0001 for 4 cycles, then 0 with timeout=1 for one cycle; ack on the expiry cycle -> timeout 0.
REQ-034 Macro off: accept code 3, ack withheld 1000 cycles -> onehot 4'b1000 held throughout, timeout always 0.
